// File: rtl/fetch_decode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the fetch/decode/execute controller:
//                opcode values, FSM state encoding and instruction field
//                positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction word layout: opcode in [7:5], operand in [4:0]
    localparam int INSTR_W = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int OPR_MSB = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Code 3 is never entered on purpose; it exists so that a corrupted
    // state register has a name and recovers to FETCH.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Extract the opcode field from an instruction word
    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_ctrl_if
//  Description : Bus bundle between the controller and its ROM / data memory,
//                plus the observable accumulator and debug outputs.
//                master : controller side (drives addresses, acc, status)
//                slave  : memory / environment side (drives read data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_decode_ctrl_if #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8,
    parameter int OPR_W  = 5
);
    import cpu_pkg::*;

    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [OPR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]  mem_data;
    logic [DATA_W-1:0]  acc;
    logic               zero;
    state_t             state;
    logic               instr_done;

    modport master (
        output rom_addr, mem_addr, acc, zero, state, instr_done,
        input  rom_data, mem_data
    );

    modport slave (
        input  rom_addr, mem_addr, acc, zero, state, instr_done,
        output rom_data, mem_data
    );

endinterface
`default_nettype wire

// File: rtl/fetch_decode_ctrl_acc_alu.sv
`default_nettype none
// ============================================================================
//  Module      : acc_alu
//  Description : Combinational accumulator ALU, result = f(op, acc, operand).
//                Ports: i_op (opcode), i_acc, i_operand -> o_result.
//                Arithmetic wraps modulo 2**DATA_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic [2:0]        i_op,
    input  wire logic [DATA_W-1:0] i_acc,
    input  wire logic [DATA_W-1:0] i_operand,
    output logic      [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OP_ADD:  o_result = i_acc + i_operand;
            OP_SUB:  o_result = i_acc - i_operand;
            OP_AND:  o_result = i_acc & i_operand;
            OP_OR:   o_result = i_acc | i_operand;
            OP_NOT:  o_result = ~i_acc;
            OP_XOR:  o_result = i_acc ^ i_operand;
            // NOP/JMP retire in DECODE and never reach the ALU result path
            default: o_result = i_acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_ctrl
//  Description : Non-pipelined fetch/decode/execute controller. Owns pc and
//                ir, runs an 8-bit accumulator.
//                clk, rst : clock, synchronous active-high reset
//                bus      : rom_addr/rom_data, mem_addr/mem_data, acc, zero,
//                           state (debug), instr_done (retire pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8,
    parameter int OPR_W  = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_decode_ctrl_if.master bus
);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_acc;
    logic               r_zero;
    state_t             r_state;
    logic               r_instr_done;

    logic [2:0]         w_op;
    logic [DATA_W-1:0]  w_alu_result;

    assign w_op = opcode_of(r_ir);

    // Addresses come straight from registers: no input-to-output paths
    assign bus.rom_addr   = r_pc;
    assign bus.mem_addr   = r_ir[OPR_W-1:0];
    assign bus.acc        = r_acc;
    assign bus.zero       = r_zero;
    assign bus.state      = r_state;
    assign bus.instr_done = r_instr_done;

    acc_alu #(
        .DATA_W    (DATA_W)
    ) u_acc_alu (
        .i_op      (w_op),
        .i_acc     (r_acc),
        .i_operand (bus.mem_data),
        .o_result  (w_alu_result)
    );

    // instr_done is registered with the retiring transition, so it is high
    // in the same cycle the new acc / pc becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_ir         <= '0;
            r_acc        <= '0;
            r_zero       <= 1'b1;
            r_state      <= ST_FETCH;
            r_instr_done <= 1'b0;
        end else begin
            r_instr_done <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= bus.rom_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_op == OP_JMP) begin
                        // Only the low PC_W operand bits address the ROM
                        r_pc         <= r_ir[PC_W-1:0];
                        r_instr_done <= 1'b1;
                        r_state      <= ST_FETCH;
                    end else if (w_op == OP_NOP) begin
                        r_instr_done <= 1'b1;
                        r_state      <= ST_FETCH;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_acc        <= w_alu_result;
                    r_zero       <= (w_alu_result == '0);
                    r_instr_done <= 1'b1;
                    r_state      <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_decode_ctrl
//  Description : Self-checking bench for fetch_decode_ctrl. Behavioural ROM
//                and data memory; expected accumulator values are queued
//                per instruction and compared on each retire pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] rom  [16];
    logic [7:0] dmem [32];

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [7:0] sb [$];
    string cur_test = "reset";

    always #5 clk = ~clk;

    fetch_decode_ctrl_if #(.PC_W(4), .DATA_W(8), .OPR_W(5)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.mem_data = dmem[bus.mem_addr];

    fetch_decode_ctrl #(
        .PC_W   (4),
        .DATA_W (8),
        .OPR_W  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s_%s observed=0x%0h expected=0x%0h", cur_test, tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and service the
    // scoreboard whenever an instruction retires.
    task automatic tick();
        logic [7:0] exp_acc;
        @(posedge clk);
        #1;
        if (bus.instr_done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb_underflow observed=retire expected=none", cur_test);
            end else begin
                exp_acc = sb.pop_front();
                check("acc", {24'd0, bus.acc}, {24'd0, exp_acc});
                check("zero", {31'd0, bus.zero}, {31'd0, (exp_acc == 8'h00)});
            end
        end
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
        for (int i = 0; i < 32; i++) dmem[i] = 8'h00;
        n_done = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
        for (int i = 0; i < 32; i++) dmem[i] = 8'h00;

        // ---------------- reset held for 3 cycles ----------------
        cur_test = "reset";
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rom_addr", {28'd0, bus.rom_addr}, 32'd0);
            check("acc", {24'd0, bus.acc}, 32'h00);
            check("zero", {31'd0, bus.zero}, 32'd1);
            check("state", {30'd0, bus.state}, {30'd0, ST_FETCH});
            check("done", {31'd0, bus.instr_done}, 32'd0);
        end

        // ---------------- program test ----------------
        cur_test = "prog";
        dmem[0] = 8'h05; dmem[1] = 8'h03; dmem[2] = 8'h0F; dmem[3] = 8'h30; dmem[4] = 8'hFF;
        rom[0] = 8'h00; rom[1] = 8'h21; rom[2] = 8'h42; rom[3] = 8'h63;
        rom[4] = 8'h84; rom[5] = 8'hA4; rom[6] = 8'h00; rom[7] = 8'hE0;
        sb.push_back(8'h05); sb.push_back(8'h02); sb.push_back(8'h02); sb.push_back(8'h32);
        sb.push_back(8'hCD); sb.push_back(8'h32); sb.push_back(8'h37); sb.push_back(8'h37);
        n_done = 0;
        rst = 1'b0;
        for (int c = 0; c < 23; c++) tick();
        check("pulses", n_done, 32'd8);
        check("jmp_rom_addr", {28'd0, bus.rom_addr}, 32'd0);
        check("jmp_state", {30'd0, bus.state}, {30'd0, ST_FETCH});
        check("sb_drained", sb.size(), 32'd0);

        // ---------------- wrap arithmetic ----------------
        enter_reset();
        cur_test = "wrap";
        dmem[5] = 8'h02; dmem[6] = 8'h03; dmem[7] = 8'h01;
        rom[0] = 8'h05; rom[1] = 8'h26; rom[2] = 8'h07;
        sb.push_back(8'h02); sb.push_back(8'hFF); sb.push_back(8'h00);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("sub_acc", {24'd0, bus.acc}, 32'hFF);
        check("sub_zero", {31'd0, bus.zero}, 32'd0);
        for (int c = 0; c < 3; c++) tick();
        check("add_acc", {24'd0, bus.acc}, 32'h00);
        check("add_zero", {31'd0, bus.zero}, 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        // ---------------- pc wrap over NOPs ----------------
        enter_reset();
        cur_test = "pcwrap";
        for (int k = 0; k < 17; k++) sb.push_back(8'h00);
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("decode_state", {30'd0, bus.state}, {30'd0, ST_DECODE});
            tick();
            check("fetch_addr", {28'd0, bus.rom_addr}, k % 16);
            check("done", {31'd0, bus.instr_done}, 32'd1);
        end
        check("pulses", n_done, 32'd17);
        check("sb_drained", sb.size(), 32'd0);

        // ---------------- reset during EXECUTE ----------------
        enter_reset();
        cur_test = "midrst";
        dmem[8] = 8'h10; dmem[0] = 8'h05;
        rom[0] = 8'h08; rom[1] = 8'h00;
        sb.push_back(8'h10);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("acc_pre", {24'd0, bus.acc}, 32'h10);
        tick();
        tick();
        check("in_execute", {30'd0, bus.state}, {30'd0, ST_EXECUTE});
        n_done = 0;
        rst = 1'b1;
        tick();
        check("acc", {24'd0, bus.acc}, 32'h00);
        check("zero", {31'd0, bus.zero}, 32'd1);
        check("rom_addr", {28'd0, bus.rom_addr}, 32'd0);
        check("state", {30'd0, bus.state}, {30'd0, ST_FETCH});
        check("done", {31'd0, bus.instr_done}, 32'd0);
        tick();
        check("no_pulse", n_done, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        // ---------------- self jump at pc=3 ----------------
        enter_reset();
        cur_test = "selfjmp";
        dmem[8] = 8'h10;
        rom[0] = 8'h08; rom[1] = 8'hC0; rom[2] = 8'hC0; rom[3] = 8'hE3;
        for (int k = 0; k < 10; k++) sb.push_back(8'h10);
        rst = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        check("first_loop_addr", {28'd0, bus.rom_addr}, 32'd3);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("mid_done", {31'd0, bus.instr_done}, 32'd0);
            tick();
            check("loop_addr", {28'd0, bus.rom_addr}, 32'd3);
            check("loop_state", {30'd0, bus.state}, {30'd0, ST_FETCH});
            check("loop_done", {31'd0, bus.instr_done}, 32'd1);
        end
        check("pulses", n_done, 32'd10);
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Control unit that sits directly downstream of the instruction ROM (4-bit address, 8-bit instruction word).
- Owns the program counter, which drives the ROM address, and latches the returned instruction into an instruction register.
- Decodes the instruction as opcode [7:5] and operand [4:0], reads the data-memory operand, and executes on an internal 8-bit accumulator.
- Runs a fetch/decode/execute FSM, one instruction at a time, no pipelining.

Parameters:
- PC_W, 4, program counter / ROM address width.
- DATA_W, 8, accumulator and data-memory word width.
- OPR_W, 5, operand (data-memory address) width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  PC_W  instruction ROM address; equals pc.
- rom_data  in  8  instruction word; combinational ROM read of rom_addr.
- mem_addr  out  OPR_W  data-memory read address; equals ir[4:0].
- mem_data  in  DATA_W  data word; combinational read of mem_addr.
- acc  out  DATA_W  accumulator.
- zero  out  1  high when acc == 0; registered alongside acc.
- state  out  2  current FSM state, for debug.
- instr_done  out  1  one-cycle pulse in the cycle an instruction retires.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, sampled only on rising clk.
- Reset values: pc=0, ir=0x00, acc=0x00, zero=1, state=FETCH, instr_done=0.
- Reset mid-instruction aborts it. acc/pc are not updated by the aborted instruction.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2; code 3 is illegal and returns to FETCH on the next edge.
- FETCH: rom_addr=pc. At the edge: ir<=rom_data, pc<=pc+1 (4-bit wrap, 15->0), state<=DECODE.
- DECODE: mem_addr=ir[4:0]; mem_data settles during this state.
  - op 111 (JMP): pc<=ir[3:0], instr_done=1, ->FETCH. ir[4] is ignored.
  - op 110 (NOP): instr_done=1, ->FETCH; no state change.
  - all other ops: ->EXECUTE.
- EXECUTE: mem_addr is still ir[4:0]. At the edge acc<=f(acc, mem_data), instr_done=1, ->FETCH.
  - 000 ADD: acc+mem_data, mod 256, carry discarded.
  - 001 SUB: acc-mem_data, mod 256, borrow discarded.
  - 010 AND, 011 OR, 101 XOR: bitwise.
  - 100 NOT: ~acc; mem_data is ignored.
- zero is updated only when acc is written. It reflects the new acc value in the same cycle acc changes.
- Latency: ALU instructions take 3 cycles; JMP and NOP take 2 cycles. instr_done is asserted in the last cycle of each instruction.
- Outputs rom_addr and mem_addr are combinational from registers, with no combinational path from inputs.
- mem_addr holds ir[4:0] in every state.
- Jump to the current address (e.g. 0xE7 at pc=7) is a legal tight loop: two-cycle period, acc unchanged.

Decomposition:
- Package cpu_pkg:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_NOT=3'b100, OP_XOR=3'b101, OP_NOP=3'b110, OP_JMP=3'b111.
  - FSM state encodings.
  - field positions OPC_MSB=7, OPC_LSB=5, OPR_MSB=4.
- One sub-module is natural: acc_alu, a combinational (op, acc, operand) -> result block, instantiated once.
- The FSM, pc, ir, acc and zero stay in fetch_decode_ctrl.

Test Plan:
- Reset, then hold rst for 3 cycles: rom_addr=0, acc=0x00, zero=1, state=FETCH, instr_done=0 throughout.
- Program test:
  - Setup: data memory [0]=0x05, [1]=0x03, [2]=0x0F, [3]=0x30, [4]=0xFF. Program 00,21,42,63,84,A4,00,E0.
  - Required acc after each instruction: 0x05, 0x02, 0x02, 0x32, 0xCD, 0x32, 0x37.
  - Then JMP: rom_addr=0 in the next FETCH; 8 instr_done pulses over 23 cycles.
- Wrap arithmetic:
  - acc=0x02, SUB with 0x03 -> acc=0xFF, zero=0.
  - Then ADD with 0x01 -> acc=0x00, zero=1.
- PC wrap: NOPs (0xC0) at ROM addresses 0..15 -> rom_addr goes 15 then 0; each NOP takes 2 cycles; acc unchanged.
- Reset mid-instruction: assert rst during the EXECUTE state of ADD [0]=0x05, acc=0x10 -> acc=0x00, pc=0, state=FETCH next cycle; no instr_done.
- Self-jump 0xE3 at pc=3: rom_addr alternates between FETCH and DECODE at 3; instr_done every 2nd cycle; acc stable.
